// File: rtl/debounce_bank_pkg.sv
// Shared constants and helpers for the switch debounce slice.
// The clog2 helper is reused by other parametrised blocks.
package debounce_bank_pkg;

  // 10 ms at a 25 MHz system clock
  localparam int DEBOUNCE_LIMIT_10MS = 250000;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_flags_t;

  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/debounce_bank_channel.sv
// One debounced switch bit: 2-flop synchroniser, stability counter,
// registered stable level and one-cycle press/release pulses.
module debounce_channel
  import debounce_bank_pkg::*;
#(
  parameter int   DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_10MS,
  parameter logic INIT_STATE     = 1'b0,
  parameter logic INVERT         = 1'b0
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        switch_raw,
  output logic        stable_r,
  output logic        rise_r,
  output logic        fall_r,
  output edge_flags_t edge_next_s
);

  localparam int               CNT_W    = clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync0_r;
  logic             sync1_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             stable_next_s;

  // Two-flop synchroniser on the (optionally inverted) raw pin
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      sync0_r <= INIT_STATE;
      sync1_r <= INIT_STATE;
    end else begin
      sync0_r <= switch_raw ^ INVERT;
      sync1_r <= sync0_r;
    end
  end

  // Next-state: any agreeing sample restarts the count; a full run of
  // mismatches commits the new level and raises exactly one edge flag
  always_comb begin
    cnt_next_s       = cnt_r;
    stable_next_s    = stable_r;
    edge_next_s.rise = 1'b0;
    edge_next_s.fall = 1'b0;
    if (sync1_r == stable_r) begin
      cnt_next_s = CNT_ZERO;
    end else if (cnt_r == CNT_MAX) begin
      cnt_next_s       = CNT_ZERO;
      stable_next_s    = sync1_r;
      edge_next_s.rise = sync1_r;
      edge_next_s.fall = ~sync1_r;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end
  end

  // Counter, stable level and edge pulse registers
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      cnt_r    <= CNT_ZERO;
      stable_r <= INIT_STATE;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
    end else begin
      cnt_r    <= cnt_next_s;
      stable_r <= stable_next_s;
      rise_r   <= edge_next_s.rise;
      fall_r   <= edge_next_s.fall;
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: NUM_CH independent channels plus a
// registered any-change flag aligned with the per-channel pulses.
module debounce_bank
  import debounce_bank_pkg::*;
#(
  parameter int                NUM_CH         = 4,
  parameter int                DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_10MS,
  parameter logic [NUM_CH-1:0] INIT_STATE     = {NUM_CH{1'b0}},
  parameter logic              INVERT         = 1'b0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic              o_Any_Change
);

  edge_flags_t       edge_next_s [NUM_CH];
  logic [NUM_CH-1:0] rise_next_s;
  logic [NUM_CH-1:0] fall_next_s;
  logic              any_change_r;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .INIT_STATE     (INIT_STATE[ch]),
      .INVERT         (INVERT)
    ) u_channel (
      .i_Clk       (i_Clk),
      .i_Reset     (i_Reset),
      .switch_raw  (i_Switch[ch]),
      .stable_r    (o_Switch[ch]),
      .rise_r      (o_Rise[ch]),
      .fall_r      (o_Fall[ch]),
      .edge_next_s (edge_next_s[ch])
    );
    assign rise_next_s[ch] = edge_next_s[ch].rise;
    assign fall_next_s[ch] = edge_next_s[ch].fall;
  end

  // Fed from next-state edge flags so it lands on the same edge as o_Rise/o_Fall
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      any_change_r <= 1'b0;
    end else begin
      any_change_r <= |{rise_next_s, fall_next_s};
    end
  end

  assign o_Any_Change = any_change_r;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench: three debounce_bank configurations checked every cycle
// against a sample-history reference model.
`timescale 1ns/1ps
module tb_debounce_bank;

  localparam int         NDUT = 3;
  localparam int         NCH  = 2;
  localparam int         LIM  [NDUT] = '{4, 4, 1};
  localparam logic [1:0] INIT [NDUT] = '{2'b00, 2'b11, 2'b00};
  localparam logic       INV  [NDUT] = '{1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sw     [NDUT];
  logic [1:0] o_sw   [NDUT];
  logic [1:0] o_rise [NDUT];
  logic [1:0] o_fall [NDUT];
  logic       o_any  [NDUT];

  int checks   = 0;
  int failures = 0;

  bit         stable_m [NDUT][NCH];
  bit         hist     [NDUT][NCH][$];
  logic [6:0] exp_q    [NDUT][$];

  always #5 clk = ~clk;

  debounce_bank #(.NUM_CH(2), .DEBOUNCE_LIMIT(LIM[0]), .INIT_STATE(INIT[0]), .INVERT(INV[0])) u_dut0 (
    .i_Clk(clk), .i_Reset(rst), .i_Switch(sw[0]), .o_Switch(o_sw[0]),
    .o_Rise(o_rise[0]), .o_Fall(o_fall[0]), .o_Any_Change(o_any[0]));
  debounce_bank #(.NUM_CH(2), .DEBOUNCE_LIMIT(LIM[1]), .INIT_STATE(INIT[1]), .INVERT(INV[1])) u_dut1 (
    .i_Clk(clk), .i_Reset(rst), .i_Switch(sw[1]), .o_Switch(o_sw[1]),
    .o_Rise(o_rise[1]), .o_Fall(o_fall[1]), .o_Any_Change(o_any[1]));
  debounce_bank #(.NUM_CH(2), .DEBOUNCE_LIMIT(LIM[2]), .INIT_STATE(INIT[2]), .INVERT(INV[2])) u_dut2 (
    .i_Clk(clk), .i_Reset(rst), .i_Switch(sw[2]), .o_Switch(o_sw[2]),
    .o_Rise(o_rise[2]), .o_Fall(o_fall[2]), .o_Any_Change(o_any[2]));

  function automatic logic [6:0] act_word(input int d);
    return {o_any[d], o_fall[d], o_rise[d], o_sw[d]};
  endfunction

  function automatic logic [6:0] reset_word(input int d);
    return {1'b0, 2'b00, 2'b00, INIT[d]};
  endfunction

  task automatic check_word(input int d, input string tag, input logic [6:0] exp_w);
    logic [6:0] got;
    got = act_word(d);
    checks++;
    if (got !== exp_w) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got{any,fall,rise,sw}=%b required=%b", tag, d, $time, got, exp_w);
    end
  endtask

  // Reference: after reset the sample history looks like INIT forever back.
  function automatic void model_reset();
    for (int d = 0; d < NDUT; d++) begin
      exp_q[d].delete();
      for (int c = 0; c < NCH; c++) begin
        stable_m[d][c] = INIT[d][c];
        hist[d][c].delete();
        for (int k = 0; k < LIM[d] + 2; k++) hist[d][c].push_back(INIT[d][c]);
      end
    end
  endfunction

  // Level flips when the LIMIT samples seen through the 2-cycle synchroniser
  // all disagree with the current stable level.
  function automatic void model_step();
    for (int d = 0; d < NDUT; d++) begin
      logic [1:0] r_exp;
      logic [1:0] f_exp;
      logic [1:0] s_vec;
      r_exp = 2'b00;
      f_exp = 2'b00;
      for (int c = 0; c < NCH; c++) begin
        bit v;
        bit all_mis;
        int n;
        v = sw[d][c] ^ INV[d];
        hist[d][c].push_back(v);
        if (hist[d][c].size() > LIM[d] + 3) void'(hist[d][c].pop_front());
        n = hist[d][c].size();
        all_mis = 1'b1;
        for (int j = 0; j < LIM[d]; j++)
          if (hist[d][c][n - 3 - j] == stable_m[d][c]) all_mis = 1'b0;
        if (all_mis) begin
          stable_m[d][c] = ~stable_m[d][c];
          if (stable_m[d][c]) r_exp[c] = 1'b1;
          else f_exp[c] = 1'b1;
        end
        s_vec[c] = stable_m[d][c];
      end
      exp_q[d].push_back({|{r_exp, f_exp}, f_exp, r_exp, s_vec});
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (rst) check_word(d, "reset_hold", reset_word(d));
        else if (exp_q[d].size() > 0) check_word(d, "cycle", exp_q[d].pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int got_cycle;
    sw[0] = 2'b00;
    sw[1] = 2'b00;
    sw[2] = 2'b00;
    tick(3);
    rst = 1'b0;
    tick(4);

    // Outputs high, then async reset with inputs held high
    sw[0] = 2'b11;
    sw[2] = 2'b11;
    tick(12);
    rst = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) check_word(d, "async_reset", reset_word(d));
    tick(2);
    rst = 1'b0;
    got_cycle = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (o_sw[0][0] && got_cycle == 0) got_cycle = k;
    end
    #1;
    checks++;
    if (got_cycle != 6) begin
      failures++;
      $display("FAIL release_latency got=%0d required=6", got_cycle);
    end
    sw[0] = 2'b00;
    sw[2] = 2'b00;
    tick(12);

    // Clean press and release on ch0
    sw[0] = 2'b01; tick(10);
    sw[0] = 2'b00; tick(12);

    // Bounce then steady high
    sw[0] = 2'b01; tick(1);
    sw[0] = 2'b00; tick(1);
    sw[0] = 2'b01; tick(1);
    sw[0] = 2'b00; tick(1);
    sw[0] = 2'b01; tick(12);
    sw[0] = 2'b00; tick(12);

    // Near-miss on ch1
    sw[0] = 2'b10; tick(3);
    sw[0] = 2'b00; tick(10);

    // Simultaneous transitions
    sw[0] = 2'b11; tick(10);
    sw[0] = 2'b00; tick(10);

    // Reset mid-count, input left high across it
    sw[0] = 2'b01; tick(4);
    rst = 1'b1; tick(1);
    rst = 1'b0; tick(12);
    sw[0] = 2'b00; tick(12);

    // Single-cycle glitch on the LIMIT=1 instance
    sw[2] = 2'b01; tick(1);
    sw[2] = 2'b00; tick(6);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      for (int d = 0; d < NDUT; d++)
        for (int c = 0; c < NCH; c++)
          if ($urandom_range(0, (d == 2) ? 2 : 7) == 0) sw[d][c] = ~sw[d][c];
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      tick(1);
    end

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
Parametrised multi-channel switch debouncer for board push-buttons and slide switches.
- Per channel: 2-flop input synchroniser, consecutive-cycle stability counter, registered stable level, one-cycle press and release pulses.
- Sits between raw board switch pins and downstream logic: counters, 7-segment drivers, FSMs.
- Replaces per-switch single-instance debouncers with one block that has a defined reset state.

Parameters:
NUM_CH, 4, number of independent switch channels (>=1)
DEBOUNCE_LIMIT, 250000, consecutive mismatching cycles required before the stable level changes (10 ms at 25 MHz); legal range >=1
INIT_STATE, {NUM_CH{1'b0}}, per-channel reset value of synchronisers and stable level
INVERT, 0, 1 = inputs are active-low; each raw input is inverted before the synchroniser

Ports:
i_Clk  input  1  system clock, 25 MHz nominal
i_Reset  input  1  asynchronous reset, active-high
i_Switch  input  NUM_CH  raw, asynchronous switch inputs
o_Switch  output  NUM_CH  debounced stable level per channel
o_Rise  output  NUM_CH  one-cycle pulse: channel stable level went 0->1
o_Fall  output  NUM_CH  one-cycle pulse: channel stable level went 1->0
o_Any_Change  output  1  OR of all o_Rise and o_Fall bits, registered with them

Behaviour:
- Reset (asynchronous, active-high): every flop updates immediately, independent of i_Clk.
  - Sync stages = INIT_STATE.
  - o_Switch = INIT_STATE.
  - All counters = 0.
  - o_Rise, o_Fall, o_Any_Change = 0.
- On reset deassertion: no pulse is produced, whatever the input level. A mismatching input is then debounced normally from count 0.
- Synchroniser: s0 <= i_Switch[i] ^ INVERT; s1 <= s0. All comparisons use s1.
- Counter width: CNT_W = clog2(DEBOUNCE_LIMIT+1), computed as a localparam. Arithmetic is unsigned. The counter never exceeds DEBOUNCE_LIMIT-1, so there is no wrap-around.
- Per channel, each rising i_Clk edge:
  - s1 == o_Switch[i]: counter <= 0.
  - s1 != o_Switch[i] and counter < DEBOUNCE_LIMIT-1: counter <= counter+1.
  - s1 != o_Switch[i] and counter == DEBOUNCE_LIMIT-1: o_Switch[i] <= s1; counter <= 0; o_Rise[i] <= s1; o_Fall[i] <= ~s1.
  - Otherwise: o_Rise[i] <= 0 and o_Fall[i] <= 0.
- Latency: a clean input step becomes visible on o_Switch after 2 sync cycles + DEBOUNCE_LIMIT cycles. o_Rise/o_Fall assert on the same edge that o_Switch updates and are high for exactly 1 cycle.
- Glitch rejection: any single cycle with s1 == o_Switch[i] clears that channel's counter; the full count restarts.
- DEBOUNCE_LIMIT=1: o_Switch follows s1 with 1 cycle delay; a pulse fires on every change.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses. o_Any_Change is a single 1-cycle pulse covering all of them.
- Two edges on one channel are separated by at least DEBOUNCE_LIMIT cycles by construction.
- Reset asserted mid-count: count is discarded and no pulse is emitted. A pulse in flight is cleared immediately.
- All outputs are driven from flops, never from a combinational path from i_Switch.

Decomposition:
- Shared constants file holds:
  - default DEBOUNCE_LIMIT_10MS = 250000 (25 MHz);
  - clog2 helper function, reused by other parametrised blocks.
- Natural sub-module: debounce_channel (sync + counter + stable level + edge flops for one bit). debounce_bank instantiates NUM_CH copies in a generate loop and ORs the edge flags.
- o_Any_Change is a separate flop fed by the OR of the next-state edge flags, so it is aligned with o_Rise/o_Fall.

Test Plan (NUM_CH=2, DEBOUNCE_LIMIT=4, INIT_STATE=0, INVERT=0 unless stated):
- Reset: hold i_Switch=2'b11, assert i_Reset mid-cycle -> all outputs 0 immediately, before the next clock edge. Deassert -> o_Switch[0] becomes 1 exactly 6 cycles later, with a single o_Rise[0] pulse.
- Clean press then release on ch0: 0->1, hold 10 cycles -> o_Switch[0]=1 at cycle 6, o_Rise[0] high only cycle 6. Then 1->0 -> o_Fall[0] pulse 6 cycles after the release.
- Bounce: ch0 pattern 1,0,1,0,1 one cycle each, then steady 1 -> no pulse during the bounce; o_Switch[0] rises 6 cycles after the last 0->1 transition.
- Near-miss: ch1 high for 3 synced cycles, then low -> o_Switch[1] stays 0, no pulses, counter returns to 0.
- Simultaneous: both channels 0->1 on the same edge -> o_Rise=2'b11 for 1 cycle and o_Any_Change=1 for exactly 1 cycle.
- Reset mid-count: ch0 high, assert i_Reset after 2 counted cycles, release it with input still high -> no pulse at reset; o_Rise[0] fires 6 cycles after release.
- Parameter corners: INVERT=1, INIT_STATE=2'b11, i_Switch=2'b00 after reset -> no change, no pulses. Separately, DEBOUNCE_LIMIT=1 with a 1-cycle glitch -> pulse pair (o_Rise then o_Fall) 1 cycle apart.
